// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_monitor
// Description : Samples the ripple-divided clock div_in in the clk domain,
//               emits a one-cycle tick per rising edge, measures the div_in
//               period in clk cycles and tracks lock / sticky error status so
//               downstream logic can run on clk with tick as an enable.
// Ports       : clk          in   system clock, posedge
//               rst_n        in   asynchronous active-low reset
//               div_in       in   divided clock, asynchronous to clk
//               clear        in   synchronous clear of err, tick_count, FSM
//               tick         out  one-cycle pulse per detected div_in rise
//               period       out  last measured period (clk cycles)
//               period_valid out  one-cycle pulse when period updates
//               lock         out  high while locked
//               err          out  sticky bad-period / stall flag
//               tick_count   out  rising edges seen, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int EXP_PERIOD  = 4,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_STALL   = 2'd3
  } state_t;

  localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]    EXP_X     = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_X     = (CNT_W+1)'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  // A saturating counter narrower than the timeout can never reach it.
  localparam bit                TO_REACH  =
    (longint'(TIMEOUT) - 1) <= ((longint'(1) << CNT_W) - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   tick_q, tick_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       tick_count_q, tick_count_d;
  logic [GOOD_W-1:0]      good_cnt_q, good_cnt_d;
  state_t                 state_q, state_d;

  logic                   rise;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W:0]         meas_x;
  logic [CNT_W:0]         diff_x;
  logic                   good;
  logic                   timeout_hit;

  always_comb begin
    sync_d         = {sync_q[SYNC_STAGES-2:0], div_in};
    hist_d         = sync_q[SYNC_STAGES-1];
    rise           = sync_q[SYNC_STAGES-1] & ~hist_q;

    // cnt+1 saturated doubles as the measured period on a rise.
    cnt_inc        = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    meas_x         = {1'b0, cnt_inc};
    diff_x         = (meas_x >= EXP_X) ? (meas_x - EXP_X) : (EXP_X - meas_x);
    good           = (diff_x <= TOL_X);
    timeout_hit    = TO_REACH && (cnt_q == TO_LAST);

    tick_d         = rise;
    cnt_d          = rise ? '0 : cnt_inc;
    period_d       = period_q;
    period_valid_d = 1'b0;
    err_d          = err_q;
    tick_count_d   = tick_count_q + CNT_W'(rise);
    good_cnt_d     = good_cnt_q;
    state_d        = state_q;

    if (clear) begin
      // Clear outranks a coincident rise: the edge still ticks but is not counted.
      state_d      = S_IDLE;
      good_cnt_d   = '0;
      err_d        = 1'b0;
      tick_count_d = '0;
    end else if (rise) begin
      unique case (state_q)
        S_IDLE, S_STALL: begin
          // First edge after idle/stall only restarts the measurement.
          state_d    = S_ACQUIRE;
          good_cnt_d = '0;
        end
        S_ACQUIRE: begin
          period_d       = cnt_inc;
          period_valid_d = 1'b1;
          if (good) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = S_LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            good_cnt_d = '0;
            err_d      = 1'b1;
          end
        end
        S_LOCKED: begin
          period_d       = cnt_inc;
          period_valid_d = 1'b1;
          if (!good) begin
            err_d      = 1'b1;
            state_d    = S_ACQUIRE;
            good_cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_hit && (state_q == S_ACQUIRE || state_q == S_LOCKED)) begin
      state_d = S_STALL;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= '0;
      hist_q         <= 1'b0;
      tick_q         <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;
      tick_count_q   <= '0;
      good_cnt_q     <= '0;
      state_q        <= S_IDLE;
    end else begin
      sync_q         <= sync_d;
      hist_q         <= hist_d;
      tick_q         <= tick_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      err_q          <= err_d;
      tick_count_q   <= tick_count_d;
      good_cnt_q     <= good_cnt_d;
      state_q        <= state_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign lock         = (state_q == S_LOCKED);
  assign err          = err_q;
  assign tick_count   = tick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_monitor
// Description : Three monitors (defaults, 4-bit counters, tolerance 1) share
//               one div_in/clear/rst_n stream; a cycle-time reference model
//               predicts every output each clk cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_monitor;

  localparam int EXP     = 4;
  localparam int LOCKN   = 3;
  localparam int TIMEOUT = 64;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_STALL = 3;

  logic clk = 1'b0;
  logic rst_n, div_in, clear;

  logic        tk0, tk1, tk2, pv0, pv1, pv2, lk0, lk1, lk2, er0, er1, er2;
  logic [15:0] per0, per2, tc0, tc2;
  logic [3:0]  per1, tc1;

  always #5 clk = ~clk;

  clk_div_monitor u_def (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .clear(clear),
    .tick(tk0), .period(per0), .period_valid(pv0), .lock(lk0), .err(er0), .tick_count(tc0));

  clk_div_monitor #(.CNT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .clear(clear),
    .tick(tk1), .period(per1), .period_valid(pv1), .lock(lk1), .err(er1), .tick_count(tc1));

  clk_div_monitor #(.TOL(1)) u_tol (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .clear(clear),
    .tick(tk2), .period(per2), .period_valid(pv2), .lock(lk2), .err(er2), .tick_count(tc2));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int cw[3]  = '{16, 4, 16};
  int tol[3] = '{0, 0, 1};
  int m_mode[3], m_last[3], m_good[3], m_per[3], m_tc[3];
  bit m_err[3], m_tk[3], m_pv[3];
  bit lv[4];      // div_in level seen at the last four posedges, [0] newest
  int ncyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = M_IDLE; m_last[i] = 0; m_good[i] = 0; m_per[i] = 0;
      m_tc[i] = 0; m_err[i] = 0; m_tk[i] = 0; m_pv[i] = 0;
    end
    for (int k = 0; k < 4; k++) lv[k] = 0;
  endtask

  task automatic model_inst(input int i, input bit r, input bit clr);
    int p, d, mx;
    mx = (1 << cw[i]) - 1;
    m_tk[i] = r;
    m_pv[i] = 0;
    if (clr) begin
      m_mode[i] = M_IDLE; m_err[i] = 0; m_tc[i] = 0; m_good[i] = 0;
    end else if (r) begin
      m_tc[i] = (m_tc[i] + 1) & mx;
      if (m_mode[i] == M_IDLE || m_mode[i] == M_STALL) begin
        m_mode[i] = M_ACQ; m_good[i] = 0;
      end else begin
        p = ncyc - m_last[i];
        if (p > mx) p = mx;
        m_per[i] = p; m_pv[i] = 1;
        d = p - EXP;
        if (d < 0) d = -d;
        if (d <= tol[i]) begin
          if (m_mode[i] == M_ACQ) begin
            m_good[i]++;
            if (m_good[i] == LOCKN) m_mode[i] = M_LOCKED;
          end
        end else begin
          m_err[i] = 1; m_mode[i] = M_ACQ; m_good[i] = 0;
        end
      end
      m_last[i] = ncyc;
    end else if ((m_mode[i] == M_ACQ || m_mode[i] == M_LOCKED) &&
                 (ncyc - m_last[i] == TIMEOUT) && (TIMEOUT - 1 <= mx)) begin
      m_mode[i] = M_STALL; m_err[i] = 1;
    end
  endtask

  // A rise is recognised two posedges after div_in is first seen high.
  task automatic model_step();
    bit r;
    ncyc++;
    if (!rst_n) model_reset();
    else begin
      lv[3] = lv[2]; lv[2] = lv[1]; lv[1] = lv[0]; lv[0] = div_in;
      r = lv[2] && !lv[3];
      for (int i = 0; i < 3; i++) model_inst(i, r, clear);
    end
  endtask

  task automatic check_all();
    chk("u_def.tick",   32'(tk0),  32'(m_tk[0]));
    chk("u_def.pvalid", 32'(pv0),  32'(m_pv[0]));
    chk("u_def.period", 32'(per0), 32'(m_per[0]));
    chk("u_def.lock",   32'(lk0),  32'(m_mode[0] == M_LOCKED));
    chk("u_def.err",    32'(er0),  32'(m_err[0]));
    chk("u_def.tcount", 32'(tc0),  32'(m_tc[0]));
    chk("u_w4.tick",    32'(tk1),  32'(m_tk[1]));
    chk("u_w4.pvalid",  32'(pv1),  32'(m_pv[1]));
    chk("u_w4.period",  32'(per1), 32'(m_per[1]));
    chk("u_w4.lock",    32'(lk1),  32'(m_mode[1] == M_LOCKED));
    chk("u_w4.err",     32'(er1),  32'(m_err[1]));
    chk("u_w4.tcount",  32'(tc1),  32'(m_tc[1]));
    chk("u_tol.tick",   32'(tk2),  32'(m_tk[2]));
    chk("u_tol.pvalid", 32'(pv2),  32'(m_pv[2]));
    chk("u_tol.period", 32'(per2), 32'(m_per[2]));
    chk("u_tol.lock",   32'(lk2),  32'(m_mode[2] == M_LOCKED));
    chk("u_tol.err",    32'(er2),  32'(m_err[2]));
    chk("u_tol.tcount", 32'(tc2),  32'(m_tc[2]));
  endtask

  // ---------------- div_in generator ----------------
  int g_per = 4, g_ph = 4;
  int plan[$];
  bit rnd_mode = 0, clr_req = 0, clr_pulse = 0, rst_req = 0, rst_low = 0;

  function automatic int pick();
    int s;
    s = int'($urandom_range(0, 19));
    if (s < 12) return 4;
    if (s < 14) return 3;
    if (s < 16) return 5;
    if (s < 19) return int'($urandom_range(2, 8));
    return int'($urandom_range(60, 72));
  endfunction

  task automatic gen_step(output bit v, output int ph);
    if (g_ph >= g_per) begin
      g_ph = 0;
      if (plan.size() > 0) g_per = plan.pop_front();
      else if (rnd_mode)   g_per = pick();
      else                 g_per = 4;
    end
    ph = g_ph;
    v  = (g_ph < ((g_per >= 4) ? 2 : 1));
    g_ph++;
  endtask

  task automatic cycle();
    bit v;
    int ph;
    @(negedge clk);
    gen_step(v, ph);
    div_in = v;
    clear  = 1'b0;
    if (clr_req && ph == 2 && g_per >= 4) begin
      clear = 1'b1; clr_req = 0;       // lands on the cycle the edge is detected
    end else if (clr_pulse) begin
      clear = 1'b1; clr_pulse = 0;
    end else if (rnd_mode && $urandom_range(0, 199) == 0) begin
      clear = 1'b1;
    end
    if (rnd_mode && $urandom_range(0, 399) == 0) rst_req = 1;
    @(posedge clk);
    model_step();
    #1 check_all();
    if (rst_low) begin
      #1 rst_n = 1'b1; rst_low = 0;
    end else if (rst_req && ph == 1) begin
      // Reset between edges while a detected rise is still in the synchronizer.
      #1 rst_n = 1'b0; rst_req = 0; rst_low = 1;
      model_reset();
      #1 check_all();
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; div_in = 1'b0; clear = 1'b0; rst_low = 1;
    model_reset();
    run(3);
    run(40);                              // steady period 4, lock on 4th tick
    plan.push_back(6);  run(40);          // one stretched period, re-lock
    clr_pulse = 1;      run(24);          // clear sticky err, re-lock
    plan.push_back(72); run(110);         // stall then recovery
    clr_pulse = 1;
    plan.push_back(4); plan.push_back(3); plan.push_back(5);
    plan.push_back(4); plan.push_back(6);
    run(60);                              // tolerance-1 acceptance then bad period
    rst_req = 1;        run(40);          // async reset mid-lock
    clr_req = 1;        run(30);          // clear coincident with a rise
    rnd_mode = 1;       run(2000);
    rnd_mode = 0;       run(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
